// File: rtl/fetch_decode_regs.sv
// fetch_decode_regs: Y86-64 fetch-side pipeline state.
//   - F register holding the predicted PC
//   - PC selection (mispredicted jXX redirect beats ret redirect)
//   - D pipeline register with stall / bubble control from the hazard unit
// Optional macro FD_PERF_EN adds stall/bubble performance counters; when it
// is undefined the counter ports read as zero and no counter flops exist.
//
// Control semantics: rst wins over everything on its edge. D_stall holds D
// and beats D_bubble; D_bubble alone loads a nop. F_stall holds F_predPC.
module fetch_decode_regs #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [3:0]  AOK      = 4'b1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  f_stat,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
);

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  logic [63:0] f_predpc;
  logic [63:0] F_predPC_q, F_predPC_d;
  logic [3:0]  D_stat_q,  D_stat_d;
  logic [3:0]  D_icode_q, D_icode_d;
  logic [3:0]  D_ifun_q,  D_ifun_d;
  logic [3:0]  D_rA_q,    D_rA_d;
  logic [3:0]  D_rB_q,    D_rB_d;
  logic [63:0] D_valC_q,  D_valC_d;
  logic [63:0] D_valP_q,  D_valP_d;

  // PC select: a not-taken jXX in M is a mispredict and has top priority
  always_comb begin
    f_pc = F_predPC_q;
    if (M_icode == I_JXX && !M_cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end
  end

  // Predict taken for jXX and call targets, otherwise fall through
  always_comb begin
    f_predpc   = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) begin
      f_predpc = f_valC;
    end
    F_predPC_d = F_predPC_q;
    if (rst) begin
      F_predPC_d = RESET_PC;
    end else if (!F_stall) begin
      F_predPC_d = f_predpc;
    end
  end

  // D register next state: rst > D_stall > D_bubble > load
  always_comb begin
    D_stat_d  = D_stat_q;
    D_icode_d = D_icode_q;
    D_ifun_d  = D_ifun_q;
    D_rA_d    = D_rA_q;
    D_rB_d    = D_rB_q;
    D_valC_d  = D_valC_q;
    D_valP_d  = D_valP_q;
    if (rst || (!D_stall && D_bubble)) begin
      D_stat_d  = AOK;
      D_icode_d = I_NOP;
      D_ifun_d  = 4'h0;
      D_rA_d    = R_NONE;
      D_rB_d    = R_NONE;
      D_valC_d  = 64'h0;
      D_valP_d  = 64'h0;
    end else if (!D_stall) begin
      D_stat_d  = f_stat;
      D_icode_d = f_icode;
      D_ifun_d  = f_ifun;
      D_rA_d    = f_rA;
      D_rB_d    = f_rB;
      D_valC_d  = f_valC;
      D_valP_d  = f_valP;
    end
  end

  // F and D pipeline registers
  always_ff @(posedge clk) begin
    F_predPC_q <= F_predPC_d;
    D_stat_q   <= D_stat_d;
    D_icode_q  <= D_icode_d;
    D_ifun_q   <= D_ifun_d;
    D_rA_q     <= D_rA_d;
    D_rB_q     <= D_rB_d;
    D_valC_q   <= D_valC_d;
    D_valP_q   <= D_valP_d;
  end

  assign F_predPC = F_predPC_q;
  assign D_stat   = D_stat_q;
  assign D_icode  = D_icode_q;
  assign D_ifun   = D_ifun_q;
  assign D_rA     = D_rA_q;
  assign D_rB     = D_rB_q;
  assign D_valC   = D_valC_q;
  assign D_valP   = D_valP_q;

`ifdef FD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counter next state; a bubble only counts when it is not masked by a stall
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (rst) begin
      stall_cnt_d  = 32'h0;
      bubble_cnt_d = 32'h0;
    end else if (D_stall) begin
      stall_cnt_d  = stall_cnt_q + 32'h1;
    end else if (D_bubble) begin
      bubble_cnt_d = bubble_cnt_q + 32'h1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    stall_cnt_q  <= stall_cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule
